// File: rtl/pipefft_dly_ctrl.sv
// Address/enable sequencer for a pipeFFT delay-line RAM: rD reproduces the wD
// written DLY input strobes earlier, with outValid aligned to the RAM read data.
module pipefft_dly_ctrl #(
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned AW     = 5,
   parameter int unsigned DLY    = 16,
   parameter int unsigned RD_LAT = 2
) (
   input  logic          clk,
   input  logic          nGrst,
   input  logic          clr,
   input  logic          inValid,
   output logic          wEn,
   output logic [AW-1:0] wAddr,
   output logic [AW-1:0] rAddr,
   output logic          outValid,
   output logic          primed,
   output logic [AW-1:0] fillCnt
);

   localparam logic [AW-1:0] DLY_M1 = AW'(DLY - 1);
   localparam logic [AW-1:0] ONE    = AW'(1);

   // Reject geometries the pointer arithmetic cannot support.
   generate
      if ((DLY < 1) || (DLY > DEPTH - 1) || (DEPTH > 64) ||
          (DEPTH != (32'(1) << AW)) || (RD_LAT < 1)) begin : g_bad_param
         $error("pipefft_dly_ctrl: illegal DEPTH/AW/DLY/RD_LAT combination");
      end
   endgenerate

   typedef enum logic {FILL, RUN} state_t;

   state_t            state;
   state_t            state_nxt;
   logic              rd_issue;
   logic [RD_LAT-1:0] vld_sr;

   assign wEn      = inValid & ~clr;
   assign rd_issue = wEn & (state == RUN);
   assign outValid = vld_sr[RD_LAT-1];

   always_ff @(posedge clk or negedge nGrst) begin
      if (!nGrst) state <= FILL;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clr)
         state_nxt = FILL;
      else if ((state == FILL) && wEn && (fillCnt == DLY_M1))
         state_nxt = RUN;
   end

   // Pointers, fill level and the read-valid pipeline; clr flushes in-flight reads.
   always_ff @(posedge clk or negedge nGrst) begin
      if (!nGrst) begin
         wAddr   <= '0;
         rAddr   <= '0;
         fillCnt <= '0;
         primed  <= 1'b0;
         vld_sr  <= '0;
      end else if (clr) begin
         wAddr   <= '0;
         rAddr   <= '0;
         fillCnt <= '0;
         primed  <= 1'b0;
         vld_sr  <= '0;
      end else begin
         if (wEn)                      wAddr   <= wAddr + ONE;
         if (rd_issue)                 rAddr   <= rAddr + ONE;
         if (wEn && (state == FILL))   fillCnt <= fillCnt + ONE;
         primed <= (state_nxt == RUN);
         vld_sr <= RD_LAT'({vld_sr, rd_issue});
      end
   end

endmodule

// File: tb/tb_pipefft_dly_ctrl.sv
// Bench for pipefft_dly_ctrl: three instances (DLY 16, 1, 31) share one stimulus,
// each with its own two-stage RAM model and a strobe-counted reference FIFO.
module tb_pipefft_dly_ctrl;

   localparam int unsigned NI     = 3;
   localparam int unsigned RD_LAT = 2;

   typedef struct {
      int          due;
      logic [15:0] d;
   } pend_t;

   logic        clk;
   logic        nGrst;
   logic        clr;
   logic        in_valid;
   logic [15:0] wd;

   logic        w_en     [NI];
   logic [4:0]  w_addr   [NI];
   logic [4:0]  r_addr   [NI];
   logic        out_valid[NI];
   logic        primed   [NI];
   logic [4:0]  fill_cnt [NI];

   logic [15:0] mem  [NI][32];
   logic [4:0]  ra_q [NI];
   logic [15:0] rd   [NI];

   logic [15:0] fifo [NI][$];
   pend_t       pend [NI][$];
   int          cnt  [NI];
   int          ov_seen[NI];
   int          cyc;
   int          checks;
   int          failures;

   pipefft_dly_ctrl #(.DEPTH(32), .AW(5), .DLY(16), .RD_LAT(RD_LAT)) u_d16 (
      .clk(clk), .nGrst(nGrst), .clr(clr), .inValid(in_valid),
      .wEn(w_en[0]), .wAddr(w_addr[0]), .rAddr(r_addr[0]),
      .outValid(out_valid[0]), .primed(primed[0]), .fillCnt(fill_cnt[0]));

   pipefft_dly_ctrl #(.DEPTH(32), .AW(5), .DLY(1), .RD_LAT(RD_LAT)) u_d1 (
      .clk(clk), .nGrst(nGrst), .clr(clr), .inValid(in_valid),
      .wEn(w_en[1]), .wAddr(w_addr[1]), .rAddr(r_addr[1]),
      .outValid(out_valid[1]), .primed(primed[1]), .fillCnt(fill_cnt[1]));

   pipefft_dly_ctrl #(.DEPTH(32), .AW(5), .DLY(31), .RD_LAT(RD_LAT)) u_d31 (
      .clk(clk), .nGrst(nGrst), .clr(clr), .inValid(in_valid),
      .wEn(w_en[2]), .wAddr(w_addr[2]), .rAddr(r_addr[2]),
      .outValid(out_valid[2]), .primed(primed[2]), .fillCnt(fill_cnt[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Micro-RAM model: registered read address, registered read data, no reset.
   always @(posedge clk) begin
      for (int i = 0; i < int'(NI); i++) begin
         if (w_en[i]) mem[i][w_addr[i]] <= wd;
         ra_q[i] <= r_addr[i];
         rd[i]   <= mem[i][ra_q[i]];
      end
   end

   function automatic int dly_of(input int i);
      case (i)
         0:       return 16;
         1:       return 1;
         default: return 31;
      endcase
   endfunction

   task automatic chk(input string tag, input int i, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s[dly=%0d] observed=%0h expected=%0h", tag, dly_of(i), obs, exp);
      end
   endtask

   task automatic ref_clear();
      for (int i = 0; i < int'(NI); i++) begin
         fifo[i].delete();
         pend[i].delete();
         cnt[i] = 0;
      end
   endtask

   // Compare registered outputs against the strobe-count view of the delay line.
   task automatic check_outputs();
      for (int i = 0; i < int'(NI); i++) begin
         int    dl;
         int    e_r;
         logic  e_ov;
         pend_t p;
         dl   = dly_of(i);
         e_r  = (cnt[i] >= dl) ? ((cnt[i] - dl) % 32) : 0;
         e_ov = (pend[i].size() > 0) && (pend[i][0].due == cyc);
         chk("wAddr",    i, 32'(w_addr[i]),   32'(cnt[i] % 32));
         chk("rAddr",    i, 32'(r_addr[i]),   32'(e_r));
         chk("fillCnt",  i, 32'(fill_cnt[i]), 32'((cnt[i] < dl) ? cnt[i] : dl));
         chk("primed",   i, 32'(primed[i]),   32'(cnt[i] >= dl));
         chk("outValid", i, 32'(out_valid[i]), 32'(e_ov));
         if (out_valid[i] === 1'b1) ov_seen[i]++;
         if (e_ov) begin
            p = pend[i].pop_front();
            chk("rD", i, 32'(rd[i]), 32'(p.d));
         end
      end
   endtask

   task automatic step(input logic iv, input logic cl);
      logic [15:0] d;
      d        = 16'($urandom);
      in_valid = iv;
      clr      = cl;
      wd       = d;
      #1;
      for (int i = 0; i < int'(NI); i++) chk("wEn", i, 32'(w_en[i]), 32'(iv & ~cl));
      @(posedge clk);
      #1;
      if (cl) begin
         ref_clear();
      end else if (iv) begin
         for (int i = 0; i < int'(NI); i++) begin
            cnt[i]++;
            fifo[i].push_back(d);
            if (fifo[i].size() > dly_of(i)) begin
               pend_t p;
               p.due = cyc + int'(RD_LAT);
               p.d   = fifo[i].pop_front();
               pend[i].push_back(p);
            end
         end
      end
      cyc++;
      check_outputs();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      cyc      = 0;
      nGrst    = 1'b0;
      clr      = 1'b0;
      in_valid = 1'b0;
      wd       = '0;
      for (int i = 0; i < int'(NI); i++) ov_seen[i] = 0;
      ref_clear();

      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      nGrst = 1'b1;
      #1;
      check_outputs();

      // Asynchronous reset with seven samples stored.
      repeat (7) step(1'b1, 1'b0);
      #2;
      nGrst = 1'b0;
      #1;
      ref_clear();
      check_outputs();
      #2;
      nGrst = 1'b1;

      // Continuous stream.
      repeat (40) step(1'b1, 1'b0);

      // clr alongside a strobe, then held with random strobes.
      step(1'b1, 1'b1);
      repeat (3) step(1'($urandom_range(0, 1)), 1'b1);
      repeat (20) step(1'b1, 1'b0);
      step(1'b1, 1'b1);

      // Bursty stream of exactly 200 strobes.
      for (int i = 0; i < int'(NI); i++) ov_seen[i] = 0;
      begin
         int n;
         n = 0;
         while (n < 200) begin
            logic v;
            v = 1'($urandom_range(0, 1));
            step(v, 1'b0);
            if (v) n++;
         end
      end
      repeat (3) step(1'b0, 1'b0);
      for (int i = 0; i < int'(NI); i++) chk("burst_count", i, 32'(ov_seen[i]), 32'(200 - dly_of(i)));

      // Continuous run across both pointer wraps.
      step(1'b0, 1'b1);
      repeat (100) step(1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0);
      for (int i = 0; i < int'(NI); i++) chk("pending_empty", i, 32'(pend[i].size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
